// File: rtl/my_div16.sv
// my_div16 - sequential restoring (shift-and-subtract) divider.
//
// Produces one quotient bit per clock over WIDTH iterations. Operands enter
// through a valid/ready handshake. The result is held in registers until the
// consumer takes it through a second valid/ready handshake.
//
// Timing:
//   - Normal divide: out_valid rises 16 clocks after the accepting edge.
//   - Divide by zero: skips the iteration loop, and out_valid is high in the
//     cycle that follows the accepting edge.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b are valid
//   in_ready   divider is idle and can accept operands (from state and rst)
//   a          dividend
//   b          divisor
//   out_valid  quotient/remainder/div_zero hold a valid result
//   out_ready  consumer accepts the result (only looked at while DONE)
//   quotient   registered quotient (all ones on divide by zero)
//   remainder  registered remainder (equals a on divide by zero)
//   div_zero   result came from a divide by zero
//
// Configuration macro:
//   MY_DIV16_SIGNED_EN
//     Defined: operands are two's-complement. Magnitudes are divided, and the
//     signs are fixed up when the result registers are loaded. This is
//     truncating division: the remainder takes the sign of the dividend.
//     Undefined (default): plain unsigned division with no sign logic.

module my_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] rem_r;      // partial remainder
  logic [WIDTH-1:0] dvd_r;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_r;      // latched divisor (magnitude in signed mode)
  logic [CNT_W-1:0] cnt_r;      // iteration counter

  logic             accept_s;
  logic             b_zero_s;
  logic             last_iter_s;
  logic [WIDTH:0]   shifted_s;
  logic             qbit_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] a_op_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] q_load_s;
  logic [WIDTH-1:0] r_load_s;

`ifdef MY_DIV16_SIGNED_EN
  logic neg_q_r;                // quotient negative: operand signs differ
  logic neg_r_r;                // remainder negative: dividend negative

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = negate(v);
    end else begin
      m = v;
    end
    return m;
  endfunction
`endif

  assign in_ready    = (state_r == IDLE) && !rst;
  assign accept_s    = in_valid && in_ready;
  assign b_zero_s    = (b == {WIDTH{1'b0}});
  assign last_iter_s = (cnt_r == LAST_ITER);

  // One restoring step. The full partial remainder is kept in the shift so
  // that divisors above 2^(WIDTH-1) still work. When shifted >= divisor,
  // the difference is below the divisor and fits in WIDTH bits.
  always_comb begin
    shifted_s  = {rem_r, dvd_r[WIDTH-1]};
    qbit_s     = (shifted_s >= {1'b0, dvs_r});
    diff_s     = shifted_s[WIDTH-1:0] - dvs_r;
    rem_next_s = shifted_s[WIDTH-1:0];
    if (qbit_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {dvd_r[WIDTH-2:0], qbit_s};
  end

  // Operand conditioning on accept, and result fixup on the DONE load.
  always_comb begin
    a_op_s   = a;
    b_op_s   = b;
    q_load_s = quo_next_s;
    r_load_s = rem_next_s;
`ifdef MY_DIV16_SIGNED_EN
    a_op_s = magnitude(a);
    b_op_s = magnitude(b);
    if (neg_q_r) begin
      q_load_s = negate(quo_next_s);
    end else begin
      q_load_s = quo_next_s;
    end
    if (neg_r_r) begin
      r_load_s = negate(rem_next_s);
    end else begin
      r_load_s = rem_next_s;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (b_zero_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r     <= {WIDTH{1'b0}};
      dvd_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (b_zero_s) begin
              quotient  <= {WIDTH{1'b1}};
              remainder <= a;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              rem_r    <= {WIDTH{1'b0}};
              dvd_r    <= a_op_s;
              dvs_r    <= b_op_s;
              cnt_r    <= {CNT_W{1'b0}};
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem_r <= rem_next_s;
          dvd_r <= quo_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_iter_s) begin
            quotient  <= q_load_s;
            remainder <= r_load_s;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MY_DIV16_SIGNED_EN
  // Sign flags captured with the operands, applied when the result is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r_r <= a[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_my_div16.sv
// Self-checking bench for my_div16.
//
// Directed cases are followed by randomized operands. Every result is checked
// against a reference built on the language's / and % operators.

module tb_my_div16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  my_div16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the arithmetic definition of the result, not a bit-level model.
  task automatic ref_div(input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] q, output logic [15:0] r, output logic dz);
`ifdef MY_DIV16_SIGNED_EN
    int sa;
    int sb;
    int qi;
    int ri;
`endif
    if (bv == 16'd0) begin
      q  = 16'hFFFF;
      r  = av;
      dz = 1'b1;
    end else begin
`ifdef MY_DIV16_SIGNED_EN
      sa = int'($signed(av));
      sb = int'($signed(bv));
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[15:0];
      r  = ri[15:0];
`else
      q = av / bv;
      r = av % bv;
`endif
      dz = 1'b0;
    end
  endtask

  // One full transaction: accept, latency, result, optional stall, handshake.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input int stall, input bit noise);
    logic [15:0] eq;
    logic [15:0] er;
    logic        ed;
    int          lat;
    int          exp_lat;
    ref_div(av, bv, eq, er, ed);
    exp_lat = (bv == 16'd0) ? 0 : 16;
    check("pre_in_ready", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      a = 16'($urandom);
      b = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_zero", 32'(div_zero), 32'(ed));
    check("busy_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_quotient", 32'(quotient), 32'(eq));
      check("stall_remainder", 32'(remainder), 32'(er));
      check("stall_div_zero", 32'(div_zero), 32'(ed));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_quotient_held", 32'(quotient), 32'(eq));
  endtask

  initial begin
    int          spurious;
    logic [15:0] ra;
    logic [15:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_high", 32'(in_ready), 32'd1);

    run_op(16'd100, 16'd7, 0, 1'b0);
    run_op(16'hFFFF, 16'd1, 0, 1'b0);
    run_op(16'd3, 16'hFFFF, 0, 1'b0);
    run_op(16'd5, 16'd0, 0, 1'b0);
    run_op(16'd1000, 16'd10, 5, 1'b0);
    run_op(16'hFFF9, 16'd2, 0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFE, 1, 1'b1);

    // Reset in the middle of the iteration loop.
    a        = 16'd1000;
    b        = 16'd10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_div_zero", 32'(div_zero), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("midrst_spurious", 32'(spurious), 32'd0);
    run_op(16'd9, 16'd2, 0, 1'b0);

    // Randomized operands with a mix of divisor ranges.
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: rb = 16'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
